// File: rtl/kv_cache_ring.sv
// Multi-head key/value cache. Each head keeps a DEPTH-entry ring that
// overwrites its oldest entry once full; a scan engine replays one head
// oldest-to-newest over valid/ready while other heads keep appending.
module kv_cache_ring #(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 256,
   parameter int NUM_HEADS  = 4,
   localparam int HW        = (NUM_HEADS > 1) ? $clog2(NUM_HEADS) : 1,
   localparam int AW        = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear,
   input  logic                  app_valid,
   output logic                  app_ready,
   input  logic [HW-1:0]         app_head,
   input  logic [DATA_WIDTH-1:0] app_k,
   input  logic [DATA_WIDTH-1:0] app_v,
   input  logic                  scan_start,
   input  logic [HW-1:0]         scan_head,
   output logic                  scan_busy,
   output logic                  scan_done,
   output logic                  rd_valid,
   input  logic                  rd_ready,
   output logic [DATA_WIDTH-1:0] rd_k,
   output logic [DATA_WIDTH-1:0] rd_v,
   output logic [AW-1:0]         rd_idx,
   output logic                  rd_last,
   input  logic [HW-1:0]         cnt_head,
   output logic [AW:0]           cnt
);

   localparam int          MEM_WORDS = NUM_HEADS * DEPTH;
   localparam logic [AW:0] CNT_FULL  = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_PRESENT} state_t;

   state_t                          state_q, state_d;
   logic [HW-1:0]                   scan_head_q, scan_head_d;
   logic [AW:0]                     n_q, n_d;
   logic [AW-1:0]                   base_q, base_d;
   logic [AW-1:0]                   idx_q, idx_d;
   logic                            scan_done_q, scan_done_d;

   logic [NUM_HEADS-1:0][AW-1:0]    wr_ptr_all;
   logic [NUM_HEADS-1:0][AW:0]      count_all;

   logic [DATA_WIDTH-1:0]           k_mem [MEM_WORDS];
   logic [DATA_WIDTH-1:0]           v_mem [MEM_WORDS];
   logic [DATA_WIDTH-1:0]           rd_k_q, rd_v_q;

   logic                            app_fire;
   logic                            last_w;
   logic [HW+AW-1:0]                wr_addr;
   logic [HW+AW-1:0]                rd_addr;

   assign scan_busy = (state_q != S_IDLE);
   // The head under scan is frozen so the replay sees a coherent snapshot.
   assign app_ready = !clear && !(scan_busy && (app_head == scan_head_q));
   assign app_fire  = app_valid && app_ready;
   assign wr_addr   = {app_head, wr_ptr_all[app_head]};
   assign rd_addr   = {scan_head_q, base_q + idx_q};
   assign last_w    = ({1'b0, idx_q} == (n_q - (AW+1)'(1)));
   assign cnt       = count_all[cnt_head];

   // Per-head append pointer and saturating fill count.
   for (genvar gi = 0; gi < NUM_HEADS; gi++) begin : g_head
      logic [AW-1:0] wr_ptr_q;
      logic [AW:0]   count_q;

      // Advance pointer on every append; count saturates at DEPTH (overwrite mode).
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            wr_ptr_q <= '0;
            count_q  <= '0;
         end else if (clear) begin
            wr_ptr_q <= '0;
            count_q  <= '0;
         end else if (app_fire && (app_head == HW'(gi))) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
            if (count_q != CNT_FULL) begin
               count_q <= count_q + (AW+1)'(1);
            end
         end
      end

      assign wr_ptr_all[gi] = wr_ptr_q;
      assign count_all[gi]  = count_q;
   end

   // Storage write port; contents are deliberately left unreset.
   always_ff @(posedge clk) begin
      if (app_fire) begin
         k_mem[wr_addr] <= app_k;
         v_mem[wr_addr] <= app_v;
      end
   end

   // Synchronous read port, loaded only in FETCH so data holds during backpressure.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_k_q <= '0;
         rd_v_q <= '0;
      end else if (state_q == S_FETCH) begin
         rd_k_q <= k_mem[rd_addr];
         rd_v_q <= v_mem[rd_addr];
      end
   end

   // Scan FSM state and snapshot registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         scan_head_q <= '0;
         n_q         <= '0;
         base_q      <= '0;
         idx_q       <= '0;
         scan_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         scan_head_q <= scan_head_d;
         n_q         <= n_d;
         base_q      <= base_d;
         idx_q       <= idx_d;
         scan_done_q <= scan_done_d;
      end
   end

   // Scan FSM next-state: snapshot (n, base) at start, then FETCH/PRESENT per beat.
   always_comb begin
      state_d     = state_q;
      scan_head_d = scan_head_q;
      n_d         = n_q;
      base_d      = base_q;
      idx_d       = idx_q;
      scan_done_d = 1'b0;
      if (clear) begin
         state_d = S_IDLE;
         idx_d   = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (scan_start) begin
                  scan_head_d = scan_head;
                  n_d         = count_all[scan_head];
                  // A full ring has its oldest entry at wr_ptr; the low bits of DEPTH are zero.
                  base_d      = wr_ptr_all[scan_head] - count_all[scan_head][AW-1:0];
                  idx_d       = '0;
                  if (count_all[scan_head] == '0) begin
                     scan_done_d = 1'b1;
                  end else begin
                     state_d = S_FETCH;
                  end
               end
            end
            S_FETCH: begin
               state_d = S_PRESENT;
            end
            S_PRESENT: begin
               if (rd_ready) begin
                  if (last_w) begin
                     state_d     = S_IDLE;
                     scan_done_d = 1'b1;
                  end else begin
                     idx_d   = idx_q + AW'(1);
                     state_d = S_FETCH;
                  end
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // Beat outputs derive from the registered state, so they hold while stalled.
   always_comb begin
      rd_valid  = (state_q == S_PRESENT);
      rd_last   = (state_q == S_PRESENT) && last_w;
      rd_idx    = idx_q;
      rd_k      = rd_k_q;
      rd_v      = rd_v_q;
      scan_done = scan_done_q;
   end

endmodule
